// File: rtl/datapath_sequencer.sv
// ----------------------------------------------------------------------------
// datapath_sequencer
//
// Purpose:
//   Control stage that sits directly in front of the register-file / ALU / mux
//   datapath. It accepts one 32-bit instruction word at a time over a
//   valid/ready handshake. Each accepted word is decoded into the datapath
//   control inputs. The instruction is then stepped through a fixed
//   DECODE -> EXEC -> WB sequence. The ALU zero flag is captured at the end of
//   EXEC, and an instruction is counted as retired when it leaves WB.
//
//   Instruction word layout:
//     [31:29] opcode       [28]    Mux_ctrl      [27:23] Write_Addr
//     [22:18] Read_Addr_1  [17:13] Read_Addr_2   [12]    wb (write back)
//     [11:0]  imm, sign-extended to DATA_W on Data_in
//
//   Timing:
//     - One instruction is accepted every 4 cycles at most.
//     - Write_Enable is high for the single WB cycle, which is the 3rd cycle
//       after the accept edge.
//     - Decoded control outputs hold their values from one accept to the next.
//
// Ports:
//   Clock        in   system clock, rising edge
//   Reset        in   asynchronous, active-high reset
//   instr_valid  in   upstream presents a word on instr
//   instr_ready  out  sequencer is idle and takes the word on this edge
//   instr        in   32-bit instruction word
//   zero         in   ALU zero flag from the datapath
//   Read_Addr_1  out  register-file read port 1 address
//   Read_Addr_2  out  register-file read port 2 address
//   Write_Addr   out  register-file write address
//   Data_in      out  sign-extended immediate
//   Write_Enable out  register-file write strobe (WB only, one cycle)
//   Mux_ctrl     out  datapath mux select (1 = immediate path)
//   opcode       out  ALU opcode
//   busy         out  an instruction is in flight
//   zero_flag    out  zero as sampled at the end of the last EXEC
//   instr_count  out  retired-instruction counter (wraps)
// ----------------------------------------------------------------------------
module datapath_sequencer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr,
    input  logic              zero,
    output logic [ADDR_W-1:0] Read_Addr_1,
    output logic [ADDR_W-1:0] Read_Addr_2,
    output logic [ADDR_W-1:0] Write_Addr,
    output logic [DATA_W-1:0] Data_in,
    output logic              Write_Enable,
    output logic              Mux_ctrl,
    output logic [2:0]        opcode,
    output logic              busy,
    output logic              zero_flag,
    output logic [CNT_W-1:0]  instr_count
);

    // ------------------------------------------------------------------
    // Instruction field positions
    // ------------------------------------------------------------------
    localparam int IMM_W      = 12;
    localparam int OPC_HI     = 31;
    localparam int OPC_LO     = 29;
    localparam int MUX_BIT    = 28;
    localparam int WA_HI      = 27;
    localparam int WA_LO      = 23;
    localparam int RA1_HI     = 22;
    localparam int RA1_LO     = 18;
    localparam int RA2_HI     = 17;
    localparam int RA2_LO     = 13;
    localparam int WB_BIT     = 12;
    localparam int IMM_HI     = 11;
    localparam int IMM_LO     = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        WB     = 2'd3
    } state_t;

    state_t state_reg;
    state_t state_next;

    // Decoded fields, held from one accept to the next
    logic [2:0]        opcode_reg;
    logic              mux_reg;
    logic [ADDR_W-1:0] write_addr_reg;
    logic [ADDR_W-1:0] read_addr_1_reg;
    logic [ADDR_W-1:0] read_addr_2_reg;
    logic              wb_reg;
    logic [IMM_W-1:0]  imm_reg;

    logic              zero_flag_reg;
    logic [CNT_W-1:0]  count_reg;

    logic              ready_c;
    logic              busy_c;
    logic              write_enable_c;
    logic              accept;
    logic [DATA_W-1:0] data_ext;

    // The handshake completes on any edge where we are idle and upstream is
    // valid. Words offered while busy are simply not taken.
    assign accept = ready_c & instr_valid;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and state-decoded outputs.
    // Write_Enable is decoded from the state here rather than registered.
    // An asynchronous reset forces the state to IDLE, and that drops the
    // strobe at once instead of at the following edge.
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        ready_c        = 1'b0;
        busy_c         = 1'b0;
        write_enable_c = 1'b0;
        case (state_reg)
            IDLE: begin
                ready_c = 1'b1;
                if (instr_valid) begin
                    state_next = DECODE;
                end
            end
            DECODE: begin
                busy_c     = 1'b1;
                state_next = EXEC;
            end
            EXEC: begin
                busy_c     = 1'b1;
                state_next = WB;
            end
            WB: begin
                busy_c         = 1'b1;
                write_enable_c = wb_reg;
                state_next     = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Field capture on accept
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            opcode_reg      <= '0;
            mux_reg         <= 1'b0;
            write_addr_reg  <= '0;
            read_addr_1_reg <= '0;
            read_addr_2_reg <= '0;
            wb_reg          <= 1'b0;
            imm_reg         <= '0;
        end else if (accept) begin
            opcode_reg      <= instr[OPC_HI:OPC_LO];
            mux_reg         <= instr[MUX_BIT];
            write_addr_reg  <= instr[WA_HI:WA_LO];
            read_addr_1_reg <= instr[RA1_HI:RA1_LO];
            read_addr_2_reg <= instr[RA2_HI:RA2_LO];
            wb_reg          <= instr[WB_BIT];
            imm_reg         <= instr[IMM_HI:IMM_LO];
        end
    end

    // ------------------------------------------------------------------
    // Zero-flag capture on the edge that closes EXEC, and the retire
    // counter on the edge that closes WB. The counter wraps naturally.
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            zero_flag_reg <= 1'b0;
            count_reg     <= '0;
        end else begin
            if (state_reg == EXEC) begin
                zero_flag_reg <= zero;
            end
            if (state_reg == WB) begin
                count_reg <= count_reg + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sign extension of the 12-bit immediate to DATA_W
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_sext
            if (gi < IMM_W) begin : g_low
                assign data_ext[gi] = imm_reg[gi];
            end else begin : g_high
                assign data_ext[gi] = imm_reg[IMM_W-1];
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Output drive
    // ------------------------------------------------------------------
    assign instr_ready  = ready_c;
    assign busy         = busy_c;
    assign Write_Enable = write_enable_c;
    assign opcode       = opcode_reg;
    assign Mux_ctrl     = mux_reg;
    assign Write_Addr   = write_addr_reg;
    assign Read_Addr_1  = read_addr_1_reg;
    assign Read_Addr_2  = read_addr_2_reg;
    assign Data_in      = data_ext;
    assign zero_flag    = zero_flag_reg;
    assign instr_count  = count_reg;

endmodule

// File: doc/datapath_sequencer.md
Name: datapath_sequencer

Overview:
Multi-cycle control stage directly upstream of the register-file/ALU/mux datapath (Ques3). Accepts 32-bit instruction words over a valid/ready handshake and decodes each into the datapath control inputs: read/write addresses, opcode, mux select, immediate data and a one-cycle write enable. Sequences each instruction through a fixed DECODE/EXEC/WB flow, captures the datapath zero flag, and counts retired instructions.

Parameters:
DATA_W, 32, width of Data_in (sign-extended immediate) driven to the datapath
ADDR_W, 5, register address width; fixed at 5 by the instruction format
CNT_W, 16, width of retired-instruction counter

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-high reset
instr_valid  input  1  upstream has an instruction on instr
instr_ready  output  1  sequencer can accept an instruction this cycle
instr  input  32  instruction word
zero  input  1  zero flag from datapath ALU
Read_Addr_1  output  ADDR_W  register-file read port 1 address
Read_Addr_2  output  ADDR_W  register-file read port 2 address
Write_Addr  output  ADDR_W  register-file write address
Data_in  output  DATA_W  sign-extended immediate to datapath
Write_Enable  output  1  register-file write strobe
Mux_ctrl  output  1  datapath mux select (1 = immediate path)
opcode  output  3  ALU opcode
busy  output  1  instruction in flight
zero_flag  output  1  zero captured in EXEC of last instruction
instr_count  output  CNT_W  retired instructions

Behaviour:
- Instruction format: [31:29] opcode, [28] Mux_ctrl, [27:23] Write_Addr, [22:18] Read_Addr_1, [17:13] Read_Addr_2, [12] wb (1 = write back), [11:0] imm, sign-extended to DATA_W on Data_in.
- Reset (async, active-high): state IDLE; all control outputs 0; Write_Enable 0; busy 0; zero_flag 0; instr_count 0. Reset asserted mid-instruction abandons it with no write; Write_Enable drops immediately, not at the next edge.
- FSM states: IDLE, DECODE, EXEC, WB.
- IDLE: instr_ready=1, busy=0. On a rising edge with instr_valid=1: register all decoded fields to outputs; go to DECODE. Without valid, stay in IDLE.
- DECODE: one cycle; instr_ready=0, busy=1; outputs stable so register-file reads settle. Go to EXEC.
- EXEC: one cycle; on its closing edge, sample zero into zero_flag. Go to WB.
- WB: one cycle. Write_Enable=1 iff wb bit was 1 (decoded combinationally from state and stored wb). On exit, instr_count increments (wraps modulo 2^CNT_W). Go to IDLE.
- Latency: accept edge to Write_Enable high = 3 cycles. Throughput: one instruction per 4 cycles.
- Control outputs (addresses, opcode, Mux_ctrl, Data_in) hold their values from the accept edge until the next accept. They do not return to 0 in IDLE.
- instr_valid while busy: ignored, no back-pressure violation. Upstream must hold its word until instr_ready.
- Write_Addr=0 is passed through unchanged; register-0 policy belongs to the register file.
- Write_Enable is never high outside WB, and never for more than one cycle per instruction.

Test Plan:
- Reset then idle: Reset=1 for 2 cycles, release, instr_valid=0 -> instr_ready=1, busy=0, Write_Enable=0, instr_count=0 for 10 cycles.
- Load immediate: instr opcode=000, Mux_ctrl=1, Write_Addr=1, wb=1, imm=12'h003 -> Data_in=32'd3, Write_Addr=1, Write_Enable=1 exactly in 3rd cycle after accept; instr_count=1.
- Negative immediate: imm=12'hFFE -> Data_in=32'hFFFFFFFE.
- Compare only: wb=0, Read_Addr_1=0, Read_Addr_2=1, ALU drives zero=1 in EXEC -> Write_Enable stays 0; zero_flag=1 after EXEC; instr_count increments.
- Back-to-back with valid held high: 3 instructions -> accepts exactly 4 cycles apart, instr_ready low for 3 cycles between them; instr_count=3.
- Reset mid-op: assert Reset during EXEC -> Write_Enable never pulses; outputs go to 0 asynchronously; after release, state is IDLE and instr_count is unchanged from 0.
